fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 16 +
 rtl/fetch_stage.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if : instruction-memory request/response bus  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : IF stage with one-entry skid buffer and redirect drain  | rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        PCWrite,
  input  wire logic        IF_ID_Write,
  input  wire logic        branch_taken,
  input  wire logic [31:0] branch_target,
  fetch_stage_if.master    imem,
  output      logic [31:0] IF_ID_pc,
  output      logic [31:0] IF_ID_instr,
  output      logic        IF_ID_valid
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;

  logic        adv;
  logic [31:0] tgt;
  logic [1:0]  unused_tgt_lsb;

  assign adv            = PCWrite & IF_ID_Write;
  assign tgt            = {branch_target[31:2], 2'b00};
  assign unused_tgt_lsb = branch_target[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;

    case (state_q)
      ST_REQ: begin
        if (branch_taken) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          pc_d       = tgt;
          // Without a response the old request must finish before re-issuing
          if (imem.imem_ready) req_addr_d = tgt;
          else                 state_d    = ST_DRAIN;
        end else if (imem.imem_ready) begin
          if (adv) begin
            if_pc_d    = req_addr_q;
            if_instr_d = imem.imem_rdata;
            if_valid_d = 1'b1;
            pc_d       = req_addr_q + 32'd4;
            req_addr_d = req_addr_q + 32'd4;
          end else begin
            skid_pc_d    = req_addr_q;
            skid_instr_d = imem.imem_rdata;
            state_d      = ST_HOLD;
          end
        end else if (IF_ID_Write) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          pc_d       = tgt;
          req_addr_d = tgt;
          state_d    = ST_REQ;
        end else if (adv) begin
          if_pc_d    = skid_pc_q;
          if_instr_d = skid_instr_q;
          if_valid_d = 1'b1;
          pc_d       = skid_pc_q + 32'd4;
          req_addr_d = skid_pc_q + 32'd4;
          state_d    = ST_REQ;
        end
      end

      ST_DRAIN: begin
        if (branch_taken) begin
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
          pc_d       = tgt;
        end else if (imem.imem_ready) begin
          req_addr_d = pc_q;
          state_d    = ST_REQ;
        end
      end

      default: state_d = ST_REQ;
    endcase

    req_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_REQ;
      req_q        <= 1'b1;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      if_pc_q      <= 32'd0;
      if_instr_q   <= NOP_INSTR;
      if_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      if_valid_q   <= if_valid_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = req_addr_q;
  assign IF_ID_pc       = if_pc_q;
  assign IF_ID_instr    = if_instr_q;
  assign IF_ID_valid    = if_valid_q;

endmodule

`default_nettype wire
